// File: rtl/frame_scheduler.sv
// Frame-slot scheduler: starts one LED transmission per frame slot and counts missed slots.
// Optional BUSY watchdog enabled by defining FRAME_SCHEDULER_TIMEOUT_EN.
module frame_scheduler #(
  parameter int FRAME_PERIOD = 1666666,
  parameter int TIMEOUT      = 10000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       frame_rdy_i,
  output logic       frame_ack_o,
  output logic       tx_start_o,
  input  logic       tx_done_i,
  output logic       frame_pulse_o,
  output logic [7:0] drop_cnt_o,
  output logic       busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  localparam logic [26:0] LP_SLOT_LAST = 27'(FRAME_PERIOD - 1);

  if (FRAME_PERIOD < 2 || FRAME_PERIOD > 134217727 || TIMEOUT < 1 || TIMEOUT > 134217727)
  begin : g_bad_params
    $error("frame_scheduler: FRAME_PERIOD or TIMEOUT out of range");
  end

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [26:0] r_slot_timer;
  logic        w_slot_tick;
  logic        r_frame_pulse;
  logic [7:0]  r_drop_cnt;
  logic        w_drop_slot;
  logic [1:0]  w_drop_inc;
  logic [8:0]  w_drop_sum;
  logic        w_timeout;

  assign w_slot_tick = (r_slot_timer == LP_SLOT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_slot_timer <= '0;
    end else if (w_slot_tick) begin
      r_slot_timer <= '0;
    end else begin
      r_slot_timer <= r_slot_timer + 27'd1;
    end
  end

`ifdef FRAME_SCHEDULER_TIMEOUT_EN
  localparam logic [26:0] LP_TIMEOUT_LAST = 27'(TIMEOUT - 1);

  logic [26:0] r_timeout_cnt;

  // Counts cycles since the start pulse, so the abort lands TIMEOUT cycles after tx_start_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_timeout_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_timeout_cnt <= '0;
    end else begin
      r_timeout_cnt <= r_timeout_cnt + 27'd1;
    end
  end

  assign w_timeout = (r_state == S_BUSY) && !tx_done_i && (r_timeout_cnt >= LP_TIMEOUT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_slot_tick && enable_i && frame_rdy_i) w_state_next = S_START;
      S_START: w_state_next = S_BUSY;
      S_BUSY:  if (tx_done_i || w_timeout) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A missed slot and a watchdog abort can land in the same cycle, so up to two drops per cycle.
  assign w_drop_slot = w_slot_tick && (r_state != S_IDLE) && frame_rdy_i && enable_i;
  assign w_drop_inc  = {1'b0, w_drop_slot} + {1'b0, w_timeout};
  assign w_drop_sum  = {1'b0, r_drop_cnt} + {7'd0, w_drop_inc};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_drop_cnt    <= '0;
      r_frame_pulse <= 1'b0;
    end else begin
      r_drop_cnt    <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      r_frame_pulse <= (r_state == S_BUSY) && tx_done_i;
    end
  end

  assign tx_start_o    = (r_state == S_START);
  assign frame_ack_o   = (r_state == S_START);
  assign busy_o        = (r_state == S_BUSY);
  assign frame_pulse_o = r_frame_pulse;
  assign drop_cnt_o    = r_drop_cnt;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler (FRAME_PERIOD=10, TIMEOUT=30); start/pulse cycles are
// queued by the stimulus and popped by a monitor. Honours FRAME_SCHEDULER_TIMEOUT_EN.
module tb_frame_scheduler;
  localparam int FP = 10;
  localparam int TO = 30;

  logic       clk_i       = 1'b0;
  logic       rst_i       = 1'b1;
  logic       enable_i    = 1'b0;
  logic       frame_rdy_i = 1'b0;
  logic       tx_done_i   = 1'b0;
  logic       frame_ack_o;
  logic       tx_start_o;
  logic       frame_pulse_o;
  logic [7:0] drop_cnt_o;
  logic       busy_o;

  int cyc;
  int doneDelay = 0;
  int doneCnt   = 0;
  int compared   = 0;
  int mismatched = 0;
  int expStart[$];
  int expPulse[$];

  frame_scheduler #(.FRAME_PERIOD(FP), .TIMEOUT(TO)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .enable_i(enable_i),
    .frame_rdy_i(frame_rdy_i),
    .frame_ack_o(frame_ack_o),
    .tx_start_o(tx_start_o),
    .tx_done_i(tx_done_i),
    .frame_pulse_o(frame_pulse_o),
    .drop_cnt_o(drop_cnt_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Cycle N is the interval after the Nth rising edge following reset release.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, $signed(actual), $signed(expected), cyc);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic en, input int delay);
    frame_rdy_i = rdy;
    enable_i    = en;
    doneDelay   = delay;
  endtask

  // Output engine model: tx_done_i high doneDelay cycles after tx_start_o; 0 means never.
  always @(negedge clk_i) begin
    tx_done_i = 1'b0;
    if (rst_i) begin
      doneCnt = 0;
    end else begin
      if (doneCnt > 0) begin
        doneCnt--;
        if (doneCnt == 0) tx_done_i = 1'b1;
      end
      if (tx_start_o && doneDelay > 0) doneCnt = doneDelay;
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (tx_start_o || frame_ack_o) begin
        checkOutput("frame_ack with tx_start", 64'(frame_ack_o), 64'(tx_start_o));
        if (expStart.size() == 0) checkOutput("unexpected tx_start cycle", 64'(cyc), -64'sd1);
        else                      checkOutput("tx_start cycle", 64'(cyc), 64'(expStart.pop_front()));
      end
      if (frame_pulse_o) begin
        if (expPulse.size() == 0) checkOutput("unexpected frame_pulse cycle", 64'(cyc), -64'sd1);
        else                      checkOutput("frame_pulse cycle", 64'(cyc), 64'(expPulse.pop_front()));
      end
    end
  end

  task automatic waitUntil(input int n);
    while (cyc < n) @(negedge clk_i);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " tx_start"}, 64'(tx_start_o), 64'd0);
    checkOutput({tag, " frame_ack"}, 64'(frame_ack_o), 64'd0);
    checkOutput({tag, " frame_pulse"}, 64'(frame_pulse_o), 64'd0);
    checkOutput({tag, " drop_cnt"}, 64'(drop_cnt_o), 64'd0);
    checkOutput({tag, " busy"}, 64'(busy_o), 64'd0);
  endtask

  task automatic resetDut(input logic rdy, input logic en, input int delay);
    @(negedge clk_i);
    rst_i = 1'b1;
    applyStimulus(rdy, en, delay);
    repeat (2) @(negedge clk_i);
    checkAllZero("reset");
    rst_i = 1'b0;
  endtask

  task automatic phaseEnd(input string tag);
    checkOutput({tag, " starts outstanding"}, 64'(expStart.size()), 64'd0);
    checkOutput({tag, " pulses outstanding"}, 64'(expPulse.size()), 64'd0);
    expStart.delete();
    expPulse.delete();
  endtask

  initial begin
    // Steady state: done 3 cycles after each start.
    expStart = '{10, 20, 30};
    expPulse = '{14, 24, 34};
    resetDut(1'b1, 1'b1, 3);
    waitUntil(35);
    applyStimulus(1'b0, 1'b1, 3);
    waitUntil(42);
    checkOutput("steady drop_cnt", 64'(drop_cnt_o), 64'd0);
    phaseEnd("steady");

    // Long transmission spans two slot ticks.
    expStart = '{10};
    expPulse = '{36};
    resetDut(1'b1, 1'b1, 25);
    waitUntil(25);
    checkOutput("long busy", 64'(busy_o), 64'd1);
    checkOutput("long drop_cnt mid", 64'(drop_cnt_o), 64'd1);
    waitUntil(37);
    applyStimulus(1'b0, 1'b1, 25);
    checkOutput("long drop_cnt", 64'(drop_cnt_o), 64'd2);
    checkOutput("long idle", 64'(busy_o), 64'd0);
    waitUntil(45);
    phaseEnd("long");

    // tx_done coincides with slot tick: that slot is skipped and counted as a drop.
    expStart = '{10, 30};
    expPulse = '{20, 40};
    resetDut(1'b1, 1'b1, 9);
    waitUntil(25);
    checkOutput("coincide idle", 64'(busy_o), 64'd0);
    checkOutput("coincide drop mid", 64'(drop_cnt_o), 64'd1);
    waitUntil(31);
    applyStimulus(1'b0, 1'b1, 9);
    waitUntil(42);
    checkOutput("coincide drop_cnt", 64'(drop_cnt_o), 64'd1);
    phaseEnd("coincide");

    // enable dropped while BUSY: frame still completes, nothing further starts.
    expStart = '{10};
    expPulse = '{16};
    resetDut(1'b1, 1'b1, 5);
    waitUntil(12);
    applyStimulus(1'b1, 1'b0, 5);
    waitUntil(45);
    checkOutput("disable drop_cnt", 64'(drop_cnt_o), 64'd0);
    checkOutput("disable busy", 64'(busy_o), 64'd0);
    phaseEnd("disable");

    // tx_done never arrives.
    expStart = '{10};
    resetDut(1'b1, 1'b1, 0);
    waitUntil(39);
    checkOutput("hang busy before abort point", 64'(busy_o), 64'd1);
    checkOutput("hang drop_cnt before abort point", 64'(drop_cnt_o), 64'd2);
`ifdef FRAME_SCHEDULER_TIMEOUT_EN
    waitUntil(40);
    checkOutput("timeout idle", 64'(busy_o), 64'd0);
    checkOutput("timeout drop_cnt", 64'(drop_cnt_o), 64'd4);
    waitUntil(41);
    applyStimulus(1'b0, 1'b1, 0);
    waitUntil(55);
    checkOutput("timeout stays idle", 64'(busy_o), 64'd0);
    checkOutput("timeout drop_cnt later", 64'(drop_cnt_o), 64'd4);
`else
    waitUntil(60);
    checkOutput("hang busy", 64'(busy_o), 64'd1);
    checkOutput("hang drop_cnt", 64'(drop_cnt_o), 64'd5);
    applyStimulus(1'b0, 1'b1, 0);
`endif
    phaseEnd("hang");

    // Saturation over 3000 slots, then reset mid-BUSY.
`ifdef FRAME_SCHEDULER_TIMEOUT_EN
    for (int k = 0; 10 + 40 * k <= 30015; k++) expStart.push_back(10 + 40 * k);
`else
    expStart.push_back(10);
`endif
    resetDut(1'b1, 1'b1, 0);
    waitUntil(30015);
    checkOutput("saturated drop_cnt", 64'(drop_cnt_o), 64'd255);
    checkOutput("saturate busy", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    #1;
    checkAllZero("async reset");
    phaseEnd("saturate");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
